// File: rtl/xcvr_reset_responder.sv
// Stand-in for the hard transceiver on the reset_control handshake: models PLL lock, calibration and CDR lock.
// Latency: cal_busy falls CAL_CYCLES edges after reset release; locks assert LOCK_CYCLES edges after the enabling edge.
// Backpressure: none; status outputs are level signals, and sequencing violations latch into sticky seq_err bits.
module xcvr_reset_responder #(
    parameter int CAL_CYCLES      = 200,
    parameter int PLL_LOCK_CYCLES = 64,
    parameter int CDR_LOCK_CYCLES = 100,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_powerdown,
    input  logic       tx_analogreset,
    input  logic       tx_digitalreset,
    input  logic       rx_analogreset,
    input  logic       rx_digitalreset,
    input  logic       rx_signal_ok,
    input  logic       err_clear,
    output logic       pll_locked,
    output logic       tx_cal_busy,
    output logic       rx_cal_busy,
    output logic       rx_is_lockedtodata,
    output logic [3:0] seq_err
);

    typedef enum logic {
        CAL_BUSY,
        CAL_DONE
    } cal_state_t;

    typedef enum logic [1:0] {
        LK_OFF,
        LK_LOCKING,
        LK_LOCKED
    } lock_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CAL_INIT = CNT_W'(CAL_CYCLES);
    localparam logic [CNT_W-1:0] PLL_LOAD = CNT_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CDR_LOAD = CNT_W'(CDR_LOCK_CYCLES - 1);

    cal_state_t  cal_state, cal_nxt;
    lock_state_t pll_state, pll_nxt;
    lock_state_t cdr_state, cdr_nxt;
    logic [CNT_W-1:0] cal_cnt, cal_cnt_nxt;
    logic [CNT_W-1:0] pll_cnt, pll_cnt_nxt;
    logic [CNT_W-1:0] cdr_cnt, cdr_cnt_nxt;

    // Previous-cycle copies of {rx_digitalreset, rx_analogreset, tx_digitalreset, tx_analogreset}
    logic [3:0] rst_q;
    logic [3:0] rst_now;
    logic [3:0] rst_fall;
    logic [3:0] err_set;
    logic       pll_en;
    logic       cdr_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cal_state          <= CAL_BUSY;
            cal_cnt            <= CAL_INIT;
            tx_cal_busy        <= 1'b1;
            rx_cal_busy        <= 1'b1;
            pll_state          <= LK_OFF;
            pll_cnt            <= '0;
            pll_locked         <= 1'b0;
            cdr_state          <= LK_OFF;
            cdr_cnt            <= '0;
            rx_is_lockedtodata <= 1'b0;
            rst_q              <= 4'hF;
            seq_err            <= 4'h0;
        end else begin
            cal_state          <= cal_nxt;
            cal_cnt            <= cal_cnt_nxt;
            tx_cal_busy        <= (cal_nxt == CAL_BUSY);
            rx_cal_busy        <= (cal_nxt == CAL_BUSY);
            pll_state          <= pll_nxt;
            pll_cnt            <= pll_cnt_nxt;
            pll_locked         <= (pll_nxt == LK_LOCKED);
            cdr_state          <= cdr_nxt;
            cdr_cnt            <= cdr_cnt_nxt;
            rx_is_lockedtodata <= (cdr_nxt == LK_LOCKED);
            rst_q              <= rst_now;
            // A violation flagged in the same cycle as a clear must survive it
            seq_err            <= (err_clear ? 4'h0 : seq_err) | err_set;
        end
    end

    always_comb begin
        cal_nxt     = cal_state;
        cal_cnt_nxt = cal_cnt;
        if (cal_cnt != '0) begin
            cal_cnt_nxt = cal_cnt - CNT_ONE;
        end
        if (cal_state == CAL_BUSY && cal_cnt_nxt == '0) begin
            cal_nxt = CAL_DONE;
        end
    end

    assign pll_en = !pll_powerdown && !tx_cal_busy;

    always_comb begin
        pll_nxt     = pll_state;
        pll_cnt_nxt = pll_cnt;
        case (pll_state)
            LK_OFF: begin
                if (pll_en) begin
                    pll_nxt     = LK_LOCKING;
                    pll_cnt_nxt = PLL_LOAD;
                end
            end
            LK_LOCKING: begin
                if (pll_cnt == '0) begin
                    pll_nxt = LK_LOCKED;
                end else begin
                    pll_cnt_nxt = pll_cnt - CNT_ONE;
                end
            end
            LK_LOCKED: pll_nxt = LK_LOCKED;
            default:   pll_nxt = LK_OFF;
        endcase
        if (pll_powerdown) begin
            pll_nxt = LK_OFF;
        end
    end

    assign cdr_en = !rx_analogreset && !rx_cal_busy && rx_signal_ok;

    always_comb begin
        cdr_nxt     = cdr_state;
        cdr_cnt_nxt = cdr_cnt;
        case (cdr_state)
            LK_OFF: begin
                if (cdr_en) begin
                    cdr_nxt     = LK_LOCKING;
                    cdr_cnt_nxt = CDR_LOAD;
                end
            end
            LK_LOCKING: begin
                if (cdr_cnt == '0) begin
                    cdr_nxt = LK_LOCKED;
                end else begin
                    cdr_cnt_nxt = cdr_cnt - CNT_ONE;
                end
            end
            LK_LOCKED: cdr_nxt = LK_LOCKED;
            default:   cdr_nxt = LK_OFF;
        endcase
        if (!cdr_en) begin
            cdr_nxt = LK_OFF;
        end
    end

    assign rst_now  = {rx_digitalreset, rx_analogreset, tx_digitalreset, tx_analogreset};
    assign rst_fall = rst_q & ~rst_now;

    always_comb begin
        err_set    = 4'h0;
        err_set[0] = rst_fall[0] && tx_cal_busy;
        err_set[1] = rst_fall[1] && (tx_analogreset || !pll_locked);
        err_set[2] = rst_fall[2] && rx_cal_busy;
        err_set[3] = rst_fall[3] && (rx_analogreset || !rx_is_lockedtodata);
    end

endmodule
